// File: rtl/ttm_pkg.sv
// Shared defaults, LOADBUS source codes and a nibble-extract helper for the TTM4 register bank.
package ttm_pkg;

  localparam int DW_DEF = 4;
  localparam int AW_DEF = 8;

  typedef enum logic [1:0] {
    LD_NONE = 2'd0,
    LD_JR   = 2'd1,
    LD_IR   = 2'd2,
    LD_OR   = 2'd3
  } ld_sel_e;

  // Words up to 256 bits; result is the dw-bit nibble idx, zero-extended to 32 bits.
  function automatic logic [31:0] nib_get(input logic [255:0] word, input int unsigned idx,
                                          input int unsigned dw);
    logic [255:0] sh;
    sh = word >> (idx * dw);
    return sh[31:0] & ((32'd1 << dw) - 32'd1);
  endfunction

endpackage

// File: rtl/ttm_ret_stack.sv
// Hardware return stack: LIFO of AW-bit addresses with occupancy, full and empty flags.
module ttm_ret_stack #(
  parameter int AW        = 8,
  parameter int STK_DEPTH = 4,
  parameter int LW        = $clog2(STK_DEPTH + 1)
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_data,
  output logic [AW-1:0] o_top,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);

  localparam int IW = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  logic [AW-1:0] r_mem [STK_DEPTH];
  logic [LW-1:0] r_lvl;
  logic [LW-1:0] w_lvl_m1;

  assign w_lvl_m1 = r_lvl - LW'(1);
  assign o_top    = r_mem[w_lvl_m1[IW-1:0]];
  assign o_level  = r_lvl;
  assign o_full   = (r_lvl == LW'(STK_DEPTH));
  assign o_empty  = (r_lvl == '0);

  // Callers gate push with full and pop with empty; push wins if both ever arrive.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl <= '0;
      for (int i = 0; i < STK_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push) begin
      r_mem[r_lvl[IW-1:0]] <= i_data;
      r_lvl                <= r_lvl + LW'(1);
    end else if (i_pop) begin
      r_lvl <= w_lvl_m1;
    end
  end

endmodule

// File: rtl/ttm_regbank.sv
// TTM4 register bank: PC with call/return stack, nibble-written JR and output registers,
// synchronised input ports and a registered LOADBUS mux.
module ttm_regbank
  import ttm_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int N_OUT     = 2,
  parameter int N_IN      = 2,
  parameter int STK_DEPTH = 4,
  parameter int NIB       = AW / DW,
  parameter int NW        = (NIB > 1) ? $clog2(NIB) : 1,
  parameter int OSW       = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  parameter int ISW       = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int SLW       = $clog2(STK_DEPTH + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                PC_INC,
  input  logic                PC_nLD,
  input  logic                nCALL,
  input  logic                nRET,
  input  logic                nPC_OPEN,
  input  logic [NIB-1:0]      nJR_ST,
  input  logic [NIB-1:0]      nOR_ST,
  input  logic [OSW-1:0]      OR_SEL,
  input  logic [1:0]          LD_SEL,
  input  logic [NW-1:0]       LD_NIB,
  input  logic [ISW-1:0]      IR_SEL,
  input  logic [DW-1:0]       STOREBUS,
  input  logic [N_IN*AW-1:0]  IR,
  output logic [AW-1:0]       PA,
  output logic [DW-1:0]       LOADBUS,
  output logic [N_OUT*AW-1:0] OR,
  output logic [SLW-1:0]      STK_LVL,
  output logic                STK_ERR
);

  logic [AW-1:0]       r_pc;
  logic [AW-1:0]       r_jr;
  logic [N_OUT*AW-1:0] r_or;
  logic [N_IN*AW-1:0]  r_ir_s1;
  logic [N_IN*AW-1:0]  r_ir_s2;
  logic [DW-1:0]       r_load;
  logic                r_ncall_d;
  logic                r_nret_d;
  logic                r_stk_err;

  logic                w_call_edge;
  logic                w_ret_edge;
  logic [AW-1:0]       w_pc_inc;
  logic                w_push;
  logic                w_pop;
  logic [AW-1:0]       w_top;
  logic                w_full;
  logic                w_empty;
  logic [SLW-1:0]      w_lvl;
  logic [AW-1:0]       w_or_word;
  logic [AW-1:0]       w_ir_word;
  logic [DW-1:0]       w_load_nxt;

  assign w_call_edge = r_ncall_d & ~nCALL;
  assign w_ret_edge  = r_nret_d & ~nRET;
  assign w_pc_inc    = r_pc + AW'(1);
  assign w_push      = w_call_edge & ~w_full;
  assign w_pop       = ~w_call_edge & w_ret_edge & ~w_empty;

  ttm_ret_stack #(.AW(AW), .STK_DEPTH(STK_DEPTH), .LW(SLW)) u_stack (
    .clk_sys (CLK),
    .rst_n   (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_top),
    .o_level (w_lvl),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A CALL edge swallows a simultaneous RET edge; the jump still happens on overflow.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pc      <= '0;
      r_ncall_d <= 1'b1;
      r_nret_d  <= 1'b1;
      r_stk_err <= 1'b0;
    end else begin
      r_ncall_d <= nCALL;
      r_nret_d  <= nRET;
      if (w_call_edge) begin
        r_pc <= r_jr;
        if (w_full) r_stk_err <= 1'b1;
      end else if (w_ret_edge) begin
        if (w_empty) r_stk_err <= 1'b1;
        else         r_pc      <= w_top;
      end else if (!PC_nLD) begin
        r_pc <= r_jr;
      end else if (PC_INC) begin
        r_pc <= w_pc_inc;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_jr <= '0;
      r_or <= '0;
    end else begin
      for (int n = 0; n < NIB; n++) begin
        if (!nJR_ST[n]) r_jr[n*DW +: DW] <= STOREBUS;
      end
      for (int k = 0; k < N_OUT; k++) begin
        for (int n = 0; n < NIB; n++) begin
          if (int'(OR_SEL) == k && !nOR_ST[n]) r_or[k*AW + n*DW +: DW] <= STOREBUS;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ir_s1 <= '0;
      r_ir_s2 <= '0;
      r_load  <= '0;
    end else begin
      r_ir_s1 <= IR;
      r_ir_s2 <= r_ir_s1;
      r_load  <= w_load_nxt;
    end
  end

  // Out-of-range selects leave the word at zero, so the loaded nibble is zero too.
  always_comb begin
    w_or_word  = '0;
    w_ir_word  = '0;
    w_load_nxt = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (int'(OR_SEL) == k) w_or_word = r_or[k*AW +: AW];
    end
    for (int k = 0; k < N_IN; k++) begin
      if (int'(IR_SEL) == k) w_ir_word = r_ir_s2[k*AW +: AW];
    end
    if (int'(LD_NIB) < NIB) begin
      case (LD_SEL)
        LD_JR:   w_load_nxt = DW'(nib_get(256'(r_jr), 32'(LD_NIB), DW));
        LD_IR:   w_load_nxt = DW'(nib_get(256'(w_ir_word), 32'(LD_NIB), DW));
        LD_OR:   w_load_nxt = DW'(nib_get(256'(w_or_word), 32'(LD_NIB), DW));
        default: w_load_nxt = '0;
      endcase
    end
  end

  assign PA      = nPC_OPEN ? '1 : r_pc;
  assign LOADBUS = r_load;
  assign OR      = r_or;
  assign STK_LVL = w_lvl;
  assign STK_ERR = r_stk_err;

endmodule
